// File: rtl/stream_pattern_matcher_pkg.sv
// Shared types and default geometry for the stream pattern matcher.
// The top and interface take these defaults as parameter values.
package stream_pattern_matcher_pkg;

  localparam int DEF_SYM_W   = 8;
  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_IDX_W   = 16;

  typedef enum logic {
    CFG,
    RUN
  } state_t;

  typedef logic [DEF_SYM_W-1:0] sym_t;

  typedef struct packed {
    sym_t sym;
    logic wild;
  } slot_t;

  // A pattern can only run if it has between 1 and max_len symbols.
  function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/stream_pattern_matcher_if.sv
// Configuration, symbol stream and match report signals of the pattern matcher.
// The master drives the pattern and symbols; the slave (the matcher) reports matches.
interface stream_pattern_matcher_if
  import stream_pattern_matcher_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int IDX_W   = DEF_IDX_W
) ();

  localparam int ADDR_W = $clog2(MAX_LEN);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);

  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [SYM_W-1:0]  cfg_sym;
  logic              cfg_wild;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_ovl;
  logic              start;
  logic              stop;
  logic              in_valid;
  logic              in_ready;
  logic [SYM_W-1:0]  in_sym;
  logic              match;
  logic [IDX_W-1:0]  match_idx;
  logic [IDX_W-1:0]  match_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_sym, cfg_wild, cfg_len, cfg_ovl,
    output start, stop, in_valid, in_sym,
    input  in_ready, match, match_idx, match_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_sym, cfg_wild, cfg_len, cfg_ovl,
    input  start, stop, in_valid, in_sym,
    output in_ready, match, match_idx, match_cnt
  );

endinterface

// File: rtl/stream_pattern_matcher_sym_history.sv
// Symbol history window: newest symbol at index 0, with a saturating fill count.
// Exposes the post-shift view so the caller can evaluate a match on the accepting edge.
module sym_history
  import stream_pattern_matcher_pkg::*;
#(
  parameter  int SYM_W   = DEF_SYM_W,
  parameter  int MAX_LEN = DEF_MAX_LEN,
  localparam int FILL_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_en,
  input  logic                            i_clr,
  input  logic [SYM_W-1:0]                i_sym,
  output logic [MAX_LEN-1:0][SYM_W-1:0]   o_nxt_hist,
  output logic [FILL_W-1:0]               o_nxt_fill
);

  logic [MAX_LEN-1:0][SYM_W-1:0] r_hist;
  logic [FILL_W-1:0]             r_fill;
  logic [MAX_LEN-1:0][SYM_W-1:0] w_nxt_hist;
  logic [FILL_W-1:0]             w_nxt_fill;

  assign w_nxt_hist = {r_hist[MAX_LEN-2:0], i_sym};
  assign w_nxt_fill = (r_fill == FILL_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;

  // NOTE: state updates use <= so every register samples pre-edge values, whatever the block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_en) begin
      r_hist <= w_nxt_hist;
      r_fill <= w_nxt_fill;
    end
  end

  assign o_nxt_hist = w_nxt_hist;
  assign o_nxt_fill = w_nxt_fill;

endmodule

// File: rtl/stream_pattern_matcher.sv
// Scans a valid/ready symbol stream for a programmable pattern with per-slot wildcards,
// reporting one registered pulse per match plus a saturating match count.
module stream_pattern_matcher
  import stream_pattern_matcher_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  stream_pattern_matcher_if.slave    bus
);

  localparam int ADDR_W = $clog2(MAX_LEN);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic [SYM_W-1:0] sym;
    logic             wild;
  } pat_slot_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  pat_slot_t [MAX_LEN-1:0]       r_pat;
  logic [LEN_W-1:0]              r_len;
  logic                          r_ovl;
  logic [LEN_W-1:0]              r_supp;
  logic [IDX_W-1:0]              r_pos;
  logic                          r_match;
  logic [IDX_W-1:0]              r_match_idx;
  logic [IDX_W-1:0]              r_match_cnt;

  logic                          w_in_ready;
  logic                          w_cfg_wr;
  logic                          w_start_ok;
  logic                          w_accept;
  logic                          w_cmp_ok;
  logic                          w_hit;
  logic [MAX_LEN-1:0][SYM_W-1:0] w_nxt_hist;
  logic [LEN_W-1:0]              w_nxt_fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= CFG;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_cfg_wr    = 1'b0;
    w_start_ok  = 1'b0;
    case (r_state)
      CFG: begin
        w_cfg_wr = bus.cfg_we;
        if (bus.start && len_ok(32'(bus.cfg_len), MAX_LEN)) begin
          w_start_ok  = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // Stop only changes the state; a symbol offered in the same cycle is still taken.
        w_in_ready = 1'b1;
        if (bus.stop) w_state_nxt = CFG;
      end
      default: w_state_nxt = CFG;
    endcase
  end

  assign w_accept = bus.in_valid & w_in_ready;

  // NOTE: the pattern store is small and must read as cleared after reset, so it is reset like any register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat <= '0;
    end else if (w_cfg_wr) begin
      r_pat[bus.cfg_addr] <= '{sym: bus.cfg_sym, wild: bus.cfg_wild};
    end
  end

  sym_history #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN)
  ) u_hist (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_accept),
    .i_clr      (w_start_ok),
    .i_sym      (bus.in_sym),
    .o_nxt_hist (w_nxt_hist),
    .o_nxt_fill (w_nxt_fill)
  );

  // Slot 0 is the oldest pattern symbol, so it lines up with hist[len-1].
  always_comb begin
    w_cmp_ok = (w_nxt_fill >= r_len);
    for (int k = 0; k < MAX_LEN; k++) begin
      if (k < int'(r_len)) begin
        if (!r_pat[ADDR_W'(int'(r_len) - 1 - k)].wild &&
            (w_nxt_hist[ADDR_W'(k)] != r_pat[ADDR_W'(int'(r_len) - 1 - k)].sym)) begin
          w_cmp_ok = 1'b0;
        end
      end
    end
  end

  assign w_hit = w_cmp_ok && (r_ovl || (r_supp == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len       <= '0;
      r_ovl       <= 1'b0;
      r_supp      <= '0;
      r_pos       <= '0;
      r_match     <= 1'b0;
      r_match_idx <= '0;
      r_match_cnt <= '0;
    end else begin
      r_match <= 1'b0;
      if (w_start_ok) begin
        r_len       <= bus.cfg_len;
        r_ovl       <= bus.cfg_ovl;
        r_supp      <= '0;
        r_pos       <= '0;
        r_match_cnt <= '0;
      end else if (w_accept) begin
        r_pos       <= r_pos + 1'b1;
        r_match     <= w_hit;
        r_match_idx <= r_pos;
        // Suppression blocks reports until the reported match has fully slid out of the window.
        if (w_hit && !r_ovl)      r_supp <= r_len - 1'b1;
        else if (r_supp != '0)    r_supp <= r_supp - 1'b1;
        if (w_hit && (r_match_cnt != '1)) r_match_cnt <= r_match_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.match     = r_match;
  assign bus.match_idx = r_match_idx;
  assign bus.match_cnt = r_match_cnt;

endmodule
